// File: rtl/wheel_velocity_estimator_if.sv
// Encoder-in / velocity-out bundle for one wheel.
//   EncA/EncB : raw quadrature channels, asynchronous to the clock
//   W         : angular velocity, sign-magnitude, Q15 rad/s
//   Count     : signed x4 edge count of the last completed window
//   Valid     : one-cycle pulse when W/Count update
//   Error     : sticky illegal-transition flag
// The slave modport belongs to the estimator; the master drives the encoder
// and consumes the results.
interface wheel_velocity_estimator_if #(
    parameter int DATAWIDTH_N = 32,
    parameter int COUNT_WIDTH = 16
);
    logic                   WHEEL_VELOCITY_EncA_In;
    logic                   WHEEL_VELOCITY_EncB_In;
    logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W_OutBus;
    logic [COUNT_WIDTH-1:0] WHEEL_VELOCITY_Count_OutBus;
    logic                   WHEEL_VELOCITY_Valid_OutHigh;
    logic                   WHEEL_VELOCITY_Error_OutHigh;

    modport master (
        output WHEEL_VELOCITY_EncA_In, WHEEL_VELOCITY_EncB_In,
        input  WHEEL_VELOCITY_W_OutBus, WHEEL_VELOCITY_Count_OutBus,
               WHEEL_VELOCITY_Valid_OutHigh, WHEEL_VELOCITY_Error_OutHigh
    );

    modport slave (
        input  WHEEL_VELOCITY_EncA_In, WHEEL_VELOCITY_EncB_In,
        output WHEEL_VELOCITY_W_OutBus, WHEEL_VELOCITY_Count_OutBus,
               WHEEL_VELOCITY_Valid_OutHigh, WHEEL_VELOCITY_Error_OutHigh
    );
endinterface

// File: rtl/wheel_velocity_estimator.sv
// Quadrature encoder front end: x4 edge decode, per-window signed edge count,
// and conversion of that count to wheel angular velocity (rad/s, Q15,
// sign-magnitude) with a serial shift-add multiplier.
// Ports:
//   WHEEL_VELOCITY_CLOCK_50     : system clock
//   WHEEL_VELOCITY_Reset_InHigh : asynchronous active-high reset
//   bus (slave)                 : encoder inputs, W/Count/Valid/Error outputs
module wheel_velocity_estimator #(
    parameter int          DATAWIDTH_N   = 32,
    parameter int          FRACTIONAL_Q  = 15,
    parameter int          COUNT_WIDTH   = 16,
    parameter int          SAMPLE_CYCLES = 500000,
    parameter logic [15:0] SCALE_Q15     = 16'd10723
) (
    input  logic                        WHEEL_VELOCITY_CLOCK_50,
    input  logic                        WHEEL_VELOCITY_Reset_InHigh,
    wheel_velocity_estimator_if.slave   bus
);
    localparam int MAG_W  = COUNT_WIDTH - 1;
    localparam int RAW_W  = MAG_W + 16;
    // Product register is wide enough for both the full raw product and the
    // output word, so the saturation test below is always a plain OR.
    localparam int PROD_W = (RAW_W > DATAWIDTH_N) ? RAW_W : DATAWIDTH_N;
    localparam int WC_W   = $clog2(SAMPLE_CYCLES);
    localparam int BC_W   = $clog2(COUNT_WIDTH);

    localparam logic signed [COUNT_WIDTH-1:0] ACC_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic signed [COUNT_WIDTH-1:0] ACC_MIN = -ACC_MAX;
    localparam logic signed [COUNT_WIDTH-1:0] ONE     = 1;

    // The scale constant carries exactly 15 fraction bits, and the window must
    // be longer than the conversion so a terminal cycle always finds IDLE.
    if (FRACTIONAL_Q != 15 || SAMPLE_CYCLES <= COUNT_WIDTH + 3) begin : g_bad_cfg
        $error("wheel_velocity_estimator: unsupported FRACTIONAL_Q or SAMPLE_CYCLES too short");
    end

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DONE} state_t;

    // ---------------- synchronizer + decode ----------------
    logic [1:0] sync1, sync2, prev_ab;     // {A,B}
    logic       step_fwd, step_rev, step_bad;

    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        case ({prev_ab, sync2})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_rev = 1'b1;
            default: ;
        endcase
    end

    assign step_bad = ((prev_ab ^ sync2) == 2'b11);

    // ---------------- accumulator / window ----------------
    logic signed [COUNT_WIDTH-1:0] acc, acc_next;
    logic        [WC_W-1:0]        wcnt;
    logic                          terminal;
    logic        [MAG_W-1:0]       mag_next;
    logic                          error_r;

    always_comb begin
        acc_next = acc;
        if (step_fwd && acc != ACC_MAX) acc_next = acc + ONE;
        if (step_rev && acc != ACC_MIN) acc_next = acc - ONE;
    end

    // Saturation at +/-ACC_MAX guarantees |count| fits in MAG_W bits.
    assign mag_next = acc_next[COUNT_WIDTH-1] ? MAG_W'(-acc_next) : acc_next[MAG_W-1:0];
    assign terminal = (wcnt == WC_W'(SAMPLE_CYCLES - 1));

    always_ff @(posedge WHEEL_VELOCITY_CLOCK_50 or posedge WHEEL_VELOCITY_Reset_InHigh) begin
        if (WHEEL_VELOCITY_Reset_InHigh) begin
            sync1   <= 2'b00;
            sync2   <= 2'b00;
            prev_ab <= 2'b00;
            acc     <= '0;
            wcnt    <= '0;
            error_r <= 1'b0;
        end else begin
            sync1   <= {bus.WHEEL_VELOCITY_EncA_In, bus.WHEEL_VELOCITY_EncB_In};
            sync2   <= sync1;
            prev_ab <= sync2;
            // The terminal cycle's own edge is already folded into acc_next,
            // which the FSM snapshots in the same cycle.
            acc     <= terminal ? '0 : acc_next;
            wcnt    <= terminal ? '0 : wcnt + WC_W'(1);
            error_r <= error_r | step_bad;
        end
    end

    // ---------------- conversion FSM ----------------
    state_t                        state;
    logic        [MAG_W-1:0]       mag_sh;
    logic        [PROD_W-1:0]      mcand, prod;
    logic        [BC_W-1:0]        bit_cnt;
    logic signed [COUNT_WIDTH-1:0] snap;
    logic        [DATAWIDTH_N-1:0] w_r;
    logic        [COUNT_WIDTH-1:0] count_r;
    logic                          valid_r;
    logic                          sat;

    assign sat = |prod[PROD_W-1:DATAWIDTH_N-1];

    always_ff @(posedge WHEEL_VELOCITY_CLOCK_50 or posedge WHEEL_VELOCITY_Reset_InHigh) begin
        if (WHEEL_VELOCITY_Reset_InHigh) begin
            state   <= S_IDLE;
            mag_sh  <= '0;
            mcand   <= '0;
            prod    <= '0;
            bit_cnt <= '0;
            snap    <= '0;
            w_r     <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (terminal) begin
                        snap    <= acc_next;
                        mag_sh  <= mag_next;
                        mcand   <= PROD_W'(SCALE_Q15);
                        prod    <= '0;
                        bit_cnt <= '0;
                        state   <= S_MULT;
                    end
                end
                S_MULT: begin
                    // LSB-first shift-add: the multiplicand moves left as the
                    // magnitude moves right.
                    if (mag_sh[0]) prod <= prod + mcand;
                    mag_sh  <= mag_sh >> 1;
                    mcand   <= mcand << 1;
                    bit_cnt <= bit_cnt + BC_W'(1);
                    if (bit_cnt == BC_W'(MAG_W - 1)) state <= S_DONE;
                end
                S_DONE: begin
                    // Negative snapshots are never zero, so the sign bit alone
                    // cannot produce a negative-zero word.
                    w_r     <= {snap[COUNT_WIDTH-1],
                                sat ? {(DATAWIDTH_N-1){1'b1}} : prod[DATAWIDTH_N-2:0]};
                    count_r <= snap;
                    valid_r <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.WHEEL_VELOCITY_W_OutBus      = w_r;
    assign bus.WHEEL_VELOCITY_Count_OutBus  = count_r;
    assign bus.WHEEL_VELOCITY_Valid_OutHigh = valid_r;
    assign bus.WHEEL_VELOCITY_Error_OutHigh = error_r;
endmodule

// File: tb/tb_wheel_velocity_estimator.sv
// Bench for wheel_velocity_estimator: a 16-bit-count and an 8-bit-count
// instance share one encoder stimulus; a behavioural model predicts every
// output each cycle, and directed literal checks pin the model.
module tb_wheel_velocity_estimator;
    localparam int SC = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enc_a = 1'b0, enc_b = 1'b0;
    int   pos = 0;

    always #5 clk = ~clk;

    wheel_velocity_estimator_if #(.DATAWIDTH_N(32), .COUNT_WIDTH(16)) bus16 ();
    wheel_velocity_estimator_if #(.DATAWIDTH_N(32), .COUNT_WIDTH(8))  bus8 ();

    assign bus16.WHEEL_VELOCITY_EncA_In = enc_a;
    assign bus16.WHEEL_VELOCITY_EncB_In = enc_b;
    assign bus8.WHEEL_VELOCITY_EncA_In  = enc_a;
    assign bus8.WHEEL_VELOCITY_EncB_In  = enc_b;

    wheel_velocity_estimator #(.COUNT_WIDTH(16), .SAMPLE_CYCLES(SC)) dut16 (
        .WHEEL_VELOCITY_CLOCK_50(clk), .WHEEL_VELOCITY_Reset_InHigh(rst), .bus(bus16.slave));
    wheel_velocity_estimator #(.COUNT_WIDTH(8), .SAMPLE_CYCLES(SC)) dut8 (
        .WHEEL_VELOCITY_CLOCK_50(clk), .WHEEL_VELOCITY_Reset_InHigh(rst), .bus(bus8.slave));

    int n_pass = 0, n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    function automatic int gpos(input logic [1:0] g);
        case (g)
            2'b00: return 0;
            2'b01: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gcode(input int p);
        case (p & 3)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [31:0] to_w(input int c);
        longint m, p;
        logic [31:0] r;
        m = (c < 0) ? -c : c;
        p = m * 10723;
        if (p > 64'h7FFF_FFFF) p = 64'h7FFF_FFFF;
        r = p[31:0];
        r[31] = (c < 0);
        return r;
    endfunction

    int          mcw [2] = '{16, 8};
    int          m_acc [2];
    int          p_due [2];
    int          p_cnt [2];
    logic [31:0] e_w [2];
    logic [15:0] e_cnt [2];
    logic        e_valid [2];
    logic        e_err [2];
    logic [1:0]  h_s1 = 2'b00, h_s2 = 2'b00, h_prev = 2'b00;
    int          ncyc = 0;
    int          d;

    // Inputs reach the decoder two clocks after capture; the window index is
    // the number of clocks since reset release.
    always @(posedge clk) begin
        if (rst) begin
            ncyc = 0;
            h_s1 = 2'b00; h_s2 = 2'b00; h_prev = 2'b00;
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 0; p_due[i] = -1; p_cnt[i] = 0;
                e_w[i] = '0; e_cnt[i] = '0; e_valid[i] = 1'b0; e_err[i] = 1'b0;
            end
        end else begin
            d = (gpos(h_s2) - gpos(h_prev)) & 3;
            for (int i = 0; i < 2; i++) begin
                int lim;
                lim = (1 << (mcw[i] - 1)) - 1;
                if (d == 1 && m_acc[i] < lim)  m_acc[i]++;
                if (d == 3 && m_acc[i] > -lim) m_acc[i]--;
                if (d == 2) e_err[i] = 1'b1;
            end
            if (ncyc % SC == SC - 1) begin
                for (int i = 0; i < 2; i++) begin
                    p_due[i] = ncyc + mcw[i] + 1;
                    p_cnt[i] = m_acc[i];
                    m_acc[i] = 0;
                end
            end
            h_prev = h_s2; h_s2 = h_s1; h_s1 = {enc_a, enc_b};
            ncyc++;
            for (int i = 0; i < 2; i++) begin
                e_valid[i] = (ncyc == p_due[i]);
                if (e_valid[i]) begin
                    e_w[i]   = to_w(p_cnt[i]);
                    e_cnt[i] = 16'(p_cnt[i]);
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model_w16",   bus16.WHEEL_VELOCITY_W_OutBus,      e_w[0]);
        chk("model_cnt16", bus16.WHEEL_VELOCITY_Count_OutBus,  e_cnt[0]);
        chk("model_vld16", bus16.WHEEL_VELOCITY_Valid_OutHigh, e_valid[0]);
        chk("model_err16", bus16.WHEEL_VELOCITY_Error_OutHigh, e_err[0]);
        chk("model_w8",    bus8.WHEEL_VELOCITY_W_OutBus,       e_w[1]);
        chk("model_cnt8",  bus8.WHEEL_VELOCITY_Count_OutBus,   e_cnt[1][7:0]);
        chk("model_vld8",  bus8.WHEEL_VELOCITY_Valid_OutHigh,  e_valid[1]);
        chk("model_err8",  bus8.WHEEL_VELOCITY_Error_OutHigh,  e_err[1]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int dir);
        @(negedge clk);
        pos = (pos + dir) & 3;
        {enc_a, enc_b} = gcode(pos);
        repeat (3) @(negedge clk);
    endtask

    task automatic fwd(input int n);
        repeat (n) step(1);
    endtask

    task automatic rev(input int n);
        repeat (n) step(-1);
    endtask

    // Returns #1 after the posedge that opens the 16-bit instance's Valid cycle.
    task automatic wait_valid();
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!bus16.WHEEL_VELOCITY_Valid_OutHigh && k < 1200);
        chk("valid_seen", bus16.WHEEL_VELOCITY_Valid_OutHigh, 1'b1);
    endtask

    task automatic lit(input string tag, input logic [15:0] c16, input logic [31:0] w16,
                       input logic [7:0] c8, input logic [31:0] w8);
        chk({tag, "_cnt16"}, bus16.WHEEL_VELOCITY_Count_OutBus, c16);
        chk({tag, "_w16"},   bus16.WHEEL_VELOCITY_W_OutBus,     w16);
        chk({tag, "_cnt8"},  bus8.WHEEL_VELOCITY_Count_OutBus,  c8);
        chk({tag, "_w8"},    bus8.WHEEL_VELOCITY_W_OutBus,      w8);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_w16"},   bus16.WHEEL_VELOCITY_W_OutBus,      32'h0);
        chk({tag, "_cnt16"}, bus16.WHEEL_VELOCITY_Count_OutBus,  16'h0);
        chk({tag, "_vld16"}, bus16.WHEEL_VELOCITY_Valid_OutHigh, 1'b0);
        chk({tag, "_err16"}, bus16.WHEEL_VELOCITY_Error_OutHigh, 1'b0);
        chk({tag, "_w8"},    bus8.WHEEL_VELOCITY_W_OutBus,       32'h0);
        chk({tag, "_err8"},  bus8.WHEEL_VELOCITY_Error_OutHigh,  1'b0);
    endtask

    initial begin
        int n;
        repeat (4) @(negedge clk);
        all_zero("reset");
        rst = 1'b0;

        // First window: 10 forward edges.
        fwd(10);
        wait_valid();
        lit("win0", 16'h000A, 32'h0001A2DE, 8'h0A, 32'h0001A2DE);

        // 100 forward edges.
        fwd(100);
        wait_valid();
        lit("fwd100", 16'h0064, 32'h00105CAC, 8'h64, 32'h00105CAC);

        // 40 reverse edges.
        rev(40);
        wait_valid();
        lit("rev40", 16'hFFD8, 32'h80068B78, 8'hD8, 32'h80068B78);

        // Idle window, then a dither that nets to zero.
        wait_valid();
        lit("idle", 16'h0000, 32'h0, 8'h00, 32'h0);
        repeat (10) begin step(1); step(-1); end
        wait_valid();
        lit("dither", 16'h0000, 32'h0, 8'h00, 32'h0);

        // Illegal double-bit jump, then legal edges.
        @(negedge clk);
        pos = (pos + 2) & 3;
        {enc_a, enc_b} = gcode(pos);
        repeat (6) @(negedge clk);
        chk("err_set16", bus16.WHEEL_VELOCITY_Error_OutHigh, 1'b1);
        chk("err_set8",  bus8.WHEEL_VELOCITY_Error_OutHigh,  1'b1);
        fwd(3);
        wait_valid();
        lit("after_bad", 16'h0003, 32'h00007DA9, 8'h03, 32'h00007DA9);
        chk("err_held", bus16.WHEEL_VELOCITY_Error_OutHigh, 1'b1);

        // Window boundary: edge decoded in T belongs to this window, edge
        // decoded in T+1 to the next. Now in cycle T+17 of the previous window.
        wait_valid();
        repeat (982) @(negedge clk);          // cycle T+998
        pos = (pos + 1) & 3; {enc_a, enc_b} = gcode(pos);
        @(negedge clk);                       // cycle T+999
        pos = (pos + 1) & 3; {enc_a, enc_b} = gcode(pos);
        wait_valid();
        lit("edge_at_T", 16'h0001, 32'h000029E3, 8'h01, 32'h000029E3);
        wait_valid();
        lit("edge_at_T1", 16'h0001, 32'h000029E3, 8'h01, 32'h000029E3);

        // Saturation of the 8-bit instance in both directions.
        fwd(200);
        wait_valid();
        lit("sat_pos", 16'h00C8, 32'h0020B958, 8'h7F, 32'h0014C79D);
        rev(200);
        wait_valid();
        lit("sat_neg", 16'hFF38, 32'h8020B958, 8'h81, 32'h8014C79D);

        // Reset mid-conversion: return the encoder to 00 first so release is
        // edge-free, then assert reset 3 cycles after the terminal cycle.
        n = 4 + ((4 - pos) & 3);
        fwd(n);
        repeat (987 - 4 * n) @(negedge clk);  // cycle T'+3
        rst = 1'b1;
        #1;
        all_zero("rst_mid");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fwd(5);
        wait_valid();
        lit("post_rst", 16'h0005, 32'h0000D16F, 8'h05, 32'h0000D16F);
        chk("post_rst_err", bus16.WHEEL_VELOCITY_Error_OutHigh, 1'b0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
